// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with sign fix-up at completion.
module execute_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [W-1:0]         result_q, result_d;
    logic [2:0]           op_q, op_d;
    logic [W-1:0]         b_q, b_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [2*W-1:0]       acc_q, acc_d;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg_wide(input logic [2*W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Operand decode at acceptance
    logic         signed_a, signed_b, sa_in, sb_in;
    logic [W-1:0] mag_a, mag_b;
    logic         div_zero, div_ovf, special;
    logic [W-1:0] special_res;

    always_comb begin
        signed_a    = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                      (op == 3'b100) || (op == 3'b110);
        signed_b    = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa_in       = signed_a & src_a[W-1];
        sb_in       = signed_b & src_b[W-1];
        mag_a       = cond_neg(src_a, sa_in);
        mag_b       = cond_neg(src_b, sb_in);
        div_zero    = op[2] && (src_b == '0);
        div_ovf     = op[2] && !op[0] && (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? src_a : '1;
        else if (div_ovf)
            special_res = op[1] ? '0 : src_a;
    end

    // One radix-2 iteration; acc = {hi, lo} where lo starts as |src_a|
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] iter;
    logic [2*W-1:0] prod;
    logic [W-1:0]   fin_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge   = rem_sh >= {1'b0, b_q};
        div_diff = rem_sh[W-1:0] - b_q;
        if (op_q[2])
            iter = {(div_ge ? div_diff : rem_sh[W-1:0]), acc_q[W-2:0], div_ge};
        else
            iter = {mul_sum, acc_q[W-1:1]};
        prod = cond_neg_wide(iter, sa_q ^ sb_q);
        if (op_q[2])
            fin_res = op_q[1] ? cond_neg(iter[2*W-1:W], sa_q) : cond_neg(iter[W-1:0], sa_q ^ sb_q);
        else
            fin_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        op_d     = op_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = op;
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    b_d   = mag_b;
                    acc_d = {{W{1'b0}}, mag_a};
                    cnt_d = CNT_WIDTH'(W - 1);
                    if (special) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = special_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = iter;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = fin_res;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_q     <= op_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
        end
    end

    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed RV32M cases plus random ops against a plain-arithmetic model.
module tb_execute_muldiv;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         stall, busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] last_exp = '0;

    always #5 clk = ~clk;

    execute_muldiv #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] sa64, ua64, sb64, ub64, p;
        int ia, ib;
        sa64 = {{32{a[31]}}, a};
        ua64 = {32'h0, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'h0, b};
        ia = a;
        ib = b;
        p = '0;
        case (f)
            3'd0: begin p = sa64 * sb64; return p[31:0];  end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == MIN && b == '1) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == '1) return '0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return MIN;
            2:       return '1;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, hold start through DONE, check latency, stall/busy and result.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] exp;
        int lat, n;
        bit special;
        exp     = model(f, a, b);
        special = f[2] && (b == 0 || (!f[0] && a == MIN && b == '1));
        lat     = special ? 0 : W;
        @(negedge clk);
        op = f; src_a = a; src_b = b; start = 1'b1;
        #1;
        chk({tag, ".stall_accept"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        src_a = $urandom;
        src_b = $urandom;
        n = 0;
        while (!done && n < W + 4) begin
            chk({tag, ".busy_stall"}, 64'({busy, stall}), 64'd3);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".result"}, 64'(result), 64'(exp));
        chk({tag, ".stall_done"}, 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".after_done"}, 64'({busy, done}), 64'd0);
        chk({tag, ".held"}, 64'(result), 64'(exp));
        last_exp = exp;
    endtask

    initial begin
        bit saw_done;
        logic [2:0] f;
        logic [W-1:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", 64'({stall, busy, done}), 64'd0);
        chk("reset.result", 64'(result), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
        run_op(3'd1, MIN, MIN, "mulh");
        run_op(3'd3, '1, '1, "mulhu");
        run_op(3'd2, '1, 32'd2, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
        run_op(3'd5, 32'd100, 32'd7, "divu");
        run_op(3'd7, 32'd100, 32'd7, "remu");
        run_op(3'd5, 32'd5, 32'd0, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, "rem_by0");
        run_op(3'd4, MIN, '1, "div_ovf");
        run_op(3'd6, MIN, '1, "rem_ovf");

        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, $sformatf("rand%0d_op%0d", i, f));
        end

        // Flush a divide partway through: no done, result keeps the previous value.
        @(negedge clk);
        op = 3'd4; src_a = $urandom; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush.idle", 64'({busy, stall, done}), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("flush.no_done", 64'(saw_done), 64'd0);
        chk("flush.result", 64'(result), 64'(last_exp));

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op = 3'd0; src_a = $urandom; src_b = $urandom; start = 1'b1;
        @(posedge clk);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        chk("rst_mid.outputs", 64'({stall, busy, done}), 64'd0);
        chk("rst_mid.result", 64'(result), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("rst_mid.no_done", 64'(saw_done), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op(3'd3, '1, '1, "mulhu_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
